module_spi_shift_datapath: RTL and testbench

//  SPI byte datapath (mode 0, MSB first) directly downstream of module_fsm_spi.

---
 rtl/spi_pkg.sv | 9 +
 rtl/module_spi_shift_datapath_sync.sv | 17 +
 rtl/module_spi_shift_datapath.sv | 77 +++++++
 tb/tb_module_spi_shift_datapath.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI datapath types and word width
package spi_pkg;
    localparam int SPI_WORD_W = 8;
    typedef enum logic [1:0] {
        SEL_DATA = 2'b00,
        SEL_ALL0 = 2'b01,
        SEL_ALL1 = 2'b10
    } tx_sel_e;
endpackage

// File: rtl/module_spi_shift_datapath_sync.sv
// module_sync_2ff: multi-flop synchroniser bringing MISO into the clk_i domain
module module_sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic miso_i,
    output logic miso_sync
);
    logic [STAGES-1:0] ff;
    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk_i) begin
        if (rst_i) ff <= '0;
        else       ff <= {ff[STAGES-2:0], miso_i};
    end
    assign miso_sync = ff[STAGES-1];
endmodule

// File: rtl/module_spi_shift_datapath.sv
// module_spi_shift_datapath: mode-0 MSB-first SPI TX/RX shift datapath
module module_spi_shift_datapath
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pos_edge_i,
    input  logic                      neg_edge_i,
    input  logic                      en_load_i,
    input  logic                      en_shift_tx_i,
    input  logic                      en_shift_rx_i,
    input  logic [1:0]                mux_all_01_sel_i,
    input  logic [DATA_W-1:0]         tx_data_i,
    input  logic                      miso_i,
    output logic                      mosi_o,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      rx_valid_o,
    output logic [$clog2(DATA_W)-1:0] bit_cnt_o
);
    localparam int CW = $clog2(DATA_W);
    logic              miso_sync;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-2:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [CW-1:0]     bit_cnt;
    logic              last_bit;
    tx_sel_e           sel;
    module_sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .miso_i   (miso_i),
        .miso_sync(miso_sync)
    );
    // TX source mux; the unused code 2'b11 falls through to the data word
    always_comb begin
        sel      = tx_sel_e'(mux_all_01_sel_i);
        load_val = sel == SEL_ALL0 ? '0 : sel == SEL_ALL1 ? '1 : tx_data_i;
        rx_next  = {rx_shift, miso_sync};
        last_bit = bit_cnt == CW'(DATA_W - 1);
    end
    // TX register holds only the bits not yet on MOSI; the MOSI flop carries the current bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift <= '0;
            mosi_o   <= 1'b0;
        end else if (en_load_i) begin
            tx_shift <= load_val[DATA_W-2:0];
            mosi_o   <= load_val[DATA_W-1];
        end else if (neg_edge_i && en_shift_tx_i) begin
            tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
            mosi_o   <= tx_shift[DATA_W-2];
        end
    end
    // RX sampling, bit counting and completed-word capture with a one-cycle valid strobe
    always_ff @(posedge clk_i) begin
        rx_valid_o <= 1'b0;
        if (rst_i) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data_o <= '0;
        end else if (en_load_i) begin
            bit_cnt <= '0;
        end else if (pos_edge_i && en_shift_rx_i) begin
            rx_shift <= rx_next[DATA_W-2:0];
            bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
            if (last_bit) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
            end
        end
    end
    assign bit_cnt_o = bit_cnt;
endmodule

// File: tb/tb_module_spi_shift_datapath.sv
// tb_module_spi_shift_datapath: directed self-checking bench for the SPI shift datapath
module tb_module_spi_shift_datapath;
    import spi_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pos_edge = 1'b0;
    logic       neg_edge = 1'b0;
    logic       en_load = 1'b0;
    logic       en_shift_tx = 1'b0;
    logic       en_shift_rx = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       miso = 1'b0;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] bit_cnt;
    int         passed = 0;
    int         total = 0;
    int         valids = 0;

    module_spi_shift_datapath dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pos_edge_i      (pos_edge),
        .neg_edge_i      (neg_edge),
        .en_load_i       (en_load),
        .en_shift_tx_i   (en_shift_tx),
        .en_shift_rx_i   (en_shift_rx),
        .mux_all_01_sel_i(sel),
        .tx_data_i       (tx_data),
        .miso_i          (miso),
        .mosi_o          (mosi),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .bit_cnt_o       (bit_cnt)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) valids++;
    endtask

    task automatic load(input logic [1:0] s, input logic [7:0] d);
        sel = s;
        tx_data = d;
        en_load = 1'b1;
        tick();
        en_load = 1'b0;
    endtask

    // n SCLK periods: MISO set at the falling edge, MOSI captured just before the rising edge
    task automatic run_bits(input logic [7:0] miso_word, input int n, output logic [7:0] mosi_word);
        mosi_word = 8'h00;
        en_shift_tx = 1'b1;
        en_shift_rx = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            miso = miso_word[i];
            repeat (3) tick();
            mosi_word[i] = mosi;
            pos_edge = 1'b1;
            tick();
            pos_edge = 1'b0;
            repeat (3) tick();
            neg_edge = 1'b1;
            tick();
            neg_edge = 1'b0;
        end
        en_shift_tx = 1'b0;
        en_shift_rx = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", mosi); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] m;
        valids = 0;
        load(SEL_DATA, 8'hA5);
        total++; if (mosi !== 1'b1) $display("FAIL basic_first_bit: got %b expected 1", mosi); else passed++;
        run_bits(8'h3C, 8, m);
        total++; if (m !== 8'hA5) $display("FAIL basic_mosi: got %h expected a5", m); else passed++;
        total++; if (rx_data !== 8'h3C) $display("FAIL basic_rx_data: got %h expected 3c", rx_data); else passed++;
        total++; if (valids !== 1) $display("FAIL basic_valid_count: got %0d expected 1", valids); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL basic_bit_cnt: got %0d expected 0", bit_cnt); else passed++;
        total++; if (mosi !== 1'b0) $display("FAIL basic_mosi_drained: got %b expected 0", mosi); else passed++;
    endtask

    task automatic test_force();
        logic [7:0] m;
        load(SEL_ALL1, 8'h00);
        run_bits(8'h12, 8, m);
        total++; if (m !== 8'hFF) $display("FAIL force_all1: got %h expected ff", m); else passed++;
        total++; if (rx_data !== 8'h12) $display("FAIL force_rx_data: got %h expected 12", rx_data); else passed++;
        load(SEL_ALL0, 8'hFF);
        run_bits(8'hE7, 8, m);
        total++; if (m !== 8'h00) $display("FAIL force_all0: got %h expected 00", m); else passed++;
        load(2'b11, 8'hC3);
        run_bits(8'h00, 8, m);
        total++; if (m !== 8'hC3) $display("FAIL force_code3_data: got %h expected c3", m); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2, r1;
        valids = 0;
        load(SEL_DATA, 8'h81);
        run_bits(8'hF0, 8, m1);
        r1 = rx_data;
        load(SEL_DATA, 8'h7E);
        run_bits(8'h0F, 8, m2);
        total++; if (m1 !== 8'h81) $display("FAIL b2b_mosi1: got %h expected 81", m1); else passed++;
        total++; if (r1 !== 8'hF0) $display("FAIL b2b_rx1: got %h expected f0", r1); else passed++;
        total++; if (m2 !== 8'h7E) $display("FAIL b2b_mosi2: got %h expected 7e", m2); else passed++;
        total++; if (rx_data !== 8'h0F) $display("FAIL b2b_rx2: got %h expected 0f", rx_data); else passed++;
        total++; if (valids !== 2) $display("FAIL b2b_valid_count: got %0d expected 2", valids); else passed++;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] m;
        valids = 0;
        load(SEL_DATA, 8'hB0);
        run_bits(8'hAA, 4, m);
        total++; if (bit_cnt !== 3'd4) $display("FAIL midrst_pre_bit_cnt: got %0d expected 4", bit_cnt); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (mosi !== 1'b0) $display("FAIL midrst_mosi: got %b expected 0", mosi); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL midrst_rx_data: got %h expected 00", rx_data); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL midrst_bit_cnt: got %0d expected 0", bit_cnt); else passed++;
        total++; if (valids !== 0) $display("FAIL midrst_no_valid: got %0d expected 0", valids); else passed++;
        load(SEL_DATA, 8'h55);
        run_bits(8'h55, 8, m);
        total++; if (m !== 8'h55) $display("FAIL midrst_next_mosi: got %h expected 55", m); else passed++;
        total++; if (rx_data !== 8'h55) $display("FAIL midrst_next_rx: got %h expected 55", rx_data); else passed++;
        total++; if (valids !== 1) $display("FAIL midrst_next_valid: got %0d expected 1", valids); else passed++;
    endtask

    task automatic test_load_priority();
        logic [7:0] m;
        valids = 0;
        load(SEL_DATA, 8'h3C);
        run_bits(8'hC0, 2, m);
        total++; if (bit_cnt !== 3'd2) $display("FAIL prio_pre_bit_cnt: got %0d expected 2", bit_cnt); else passed++;
        sel = SEL_DATA;
        tx_data = 8'h80;
        en_load = 1'b1;
        en_shift_tx = 1'b1;
        en_shift_rx = 1'b1;
        neg_edge = 1'b1;
        pos_edge = 1'b1;
        tick();
        en_load = 1'b0;
        neg_edge = 1'b0;
        pos_edge = 1'b0;
        en_shift_rx = 1'b0;
        total++; if (mosi !== 1'b1) $display("FAIL prio_mosi: got %b expected 1", mosi); else passed++;
        total++; if (bit_cnt !== 3'd0) $display("FAIL prio_bit_cnt: got %0d expected 0", bit_cnt); else passed++;
        neg_edge = 1'b1;
        tick();
        neg_edge = 1'b0;
        en_shift_tx = 1'b0;
        total++; if (mosi !== 1'b0) $display("FAIL prio_second_bit: got %b expected 0", mosi); else passed++;
        total++; if (rx_data !== 8'h55) $display("FAIL prio_rx_hold: got %h expected 55", rx_data); else passed++;
        total++; if (valids !== 0) $display("FAIL prio_no_valid: got %0d expected 0", valids); else passed++;
    endtask

    task automatic test_idle();
        logic [7:0] m;
        load(SEL_DATA, 8'hB0);
        run_bits(8'hFF, 3, m);
        valids = 0;
        for (int i = 0; i < 16; i++) begin
            pos_edge = i[0];
            neg_edge = ~i[0];
            miso = i[1];
            tick();
        end
        pos_edge = 1'b0;
        neg_edge = 1'b0;
        total++; if (mosi !== 1'b1) $display("FAIL idle_mosi: got %b expected 1", mosi); else passed++;
        total++; if (rx_data !== 8'h55) $display("FAIL idle_rx_data: got %h expected 55", rx_data); else passed++;
        total++; if (bit_cnt !== 3'd3) $display("FAIL idle_bit_cnt: got %0d expected 3", bit_cnt); else passed++;
        total++; if (valids !== 0) $display("FAIL idle_no_valid: got %0d expected 0", valids); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_force();
        test_back_to_back();
        test_reset_mid_word();
        test_load_priority();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
